// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the fetch stage, main decoder and immediate extender.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int DROP_W = 8;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_buffer_risc_v.sv
// Ring of fetch slots {pc, instr, filled}: slots are reserved at request accept,
// filled in order by memory responses and popped in order into the IF/ID register.
module fetch_buffer_risc_v
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output logic            head_filled,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr,
  output logic [CW-1:0]   used,
  output logic [CW-1:0]   unfilled
);

  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    alloc_ptr;
  logic [PW-1:0]    fill_ptr;
  logic [PW-1:0]    pop_ptr;
  logic             fill_ok;

  assign fill_ok     = fill && (unfilled != '0);
  assign head_filled = (used != '0) && filled_q[pop_ptr];
  assign head_pc     = pc_q[pop_ptr];
  assign head_instr  = instr_q[pop_ptr];

  // A slot being popped may be re-reserved in the same cycle; fill never targets it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      pop_ptr   <= '0;
      filled_q  <= '0;
      used      <= '0;
      unfilled  <= '0;
    end else begin
      if (alloc) begin
        alloc_ptr           <= alloc_ptr + PW'(1);
        filled_q[alloc_ptr] <= 1'b0;
      end
      if (fill_ok) begin
        fill_ptr           <= fill_ptr + PW'(1);
        filled_q[fill_ptr] <= 1'b1;
      end
      if (pop)
        pop_ptr <= pop_ptr + PW'(1);
      used     <= used + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc)
      pc_q[alloc_ptr] <= alloc_pc;
    if (fill_ok)
      instr_q[fill_ptr] <= fill_data;
  end

endmodule

// File: rtl/fetch_stage_risc_v.sv
// Instruction fetch stage plus IF/ID register: in-order imem requests, fetch buffer,
// decode stall handling and EX redirects that discard wrong-path responses.
module fetch_stage_risc_v
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [31:0] ImemAddr,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       pcf;
  logic [DROP_W-1:0] drop_cnt;
  logic [CW-1:0]     used;
  logic [CW-1:0]     unfilled;
  logic              head_filled;
  logic [31:0]       head_pc;
  logic [31:0]       head_instr;
  logic              pop;
  logic              accept;
  logic              fill;

  // A slot popped this cycle is already free, so a full buffer can still stream.
  assign pop          = !PCSrcE && !StallD && head_filled;
  assign ImemReqValid = !reset && !PCSrcE && ((used - CW'(pop)) < CW'(FIFO_DEPTH));
  assign accept       = ImemReqValid && ImemReqReady;
  assign fill         = ImemRspValid && (drop_cnt == '0);
  assign ImemAddr     = pcf;

  fetch_buffer_risc_v #(
    .DEPTH (FIFO_DEPTH)
  ) u_buffer (
    .clk         (clk),
    .reset       (reset),
    .flush       (PCSrcE),
    .alloc       (accept),
    .alloc_pc    (pcf),
    .fill        (fill),
    .fill_data   (ImemRspData),
    .pop         (pop),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_instr  (head_instr),
    .used        (used),
    .unfilled    (unfilled)
  );

  // On redirect every response still owed by memory becomes wrong-path and is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcf      <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      if (ImemRspValid)
        assert (drop_cnt != '0 || unfilled != '0);
      if (PCSrcE) begin
        pcf      <= align_pc(PCTargetE);
        drop_cnt <= drop_cnt + DROP_W'(unfilled) - DROP_W'(ImemRspValid);
      end else begin
        if (accept)
          pcf <= pcf + 32'd4;
        if (ImemRspValid && !fill)
          drop_cnt <= drop_cnt - DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ValidD   <= 1'b0;
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (PCSrcE) begin
      ValidD <= 1'b0;
      InstrD <= NOP_INSTR;
    end else if (!StallD) begin
      if (head_filled) begin
        ValidD   <= 1'b1;
        InstrD   <= head_instr;
        PCD      <= head_pc;
        PCPlus4D <= head_pc + 32'd4;
      end else begin
        ValidD <= 1'b0;
        InstrD <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage_risc_v.sv
// Self-checking bench: queue-based fetch model plus in-order memory responder with random latency.
module tb_fetch_stage_risc_v;
  import riscv_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ImemReqValid;
  logic        ImemReqReady = 1'b0;
  logic [31:0] ImemAddr;
  logic        ImemRspValid = 1'b0;
  logic [31:0] ImemRspData = '0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        StallD = 1'b0;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  fetch_stage_risc_v #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ImemReqValid (ImemReqValid),
    .ImemReqReady (ImemReqReady),
    .ImemAddr     (ImemAddr),
    .ImemRspValid (ImemRspValid),
    .ImemRspData  (ImemRspData),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .StallD       (StallD),
    .ValidD       (ValidD),
    .InstrD       (InstrD),
    .PCD          (PCD),
    .PCPlus4D     (PCPlus4D)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } slot_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memreq_t;

  slot_t       slots[$];
  memreq_t     memQ[$];
  logic [31:0] mPcf = RST_PC;
  int          mDrop = 0;
  logic        mValidD = 1'b0;
  logic [31:0] mInstrD = NOP_INSTR;
  logic [31:0] mPcD = '0;
  logic [31:0] mPc4D = '0;
  bit          armed = 0;
  int          cycle = 0;
  int          lat = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr == 32'h0) ? 32'h0050_0093 : (addr ^ 32'h5A5A_0013);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cycle, actual, expected);
    end
  endtask

  // Compare DUT against the model for this cycle, then advance the model over the coming edge.
  task automatic modelStep();
    bit pop;
    bit req;
    int unfilledCnt;
    int k;
    pop = !PCSrcE && !StallD && (slots.size() > 0) && slots[0].filled;
    req = !reset && !PCSrcE && ((slots.size() - (pop ? 1 : 0)) < DEPTH);
    checkOutput("ImemReqValid", {31'b0, ImemReqValid}, {31'b0, req});
    if (req)
      checkOutput("ImemAddr", ImemAddr, mPcf);
    if (armed) begin
      checkOutput("ValidD", {31'b0, ValidD}, {31'b0, mValidD});
      checkOutput("InstrD", InstrD, mInstrD);
      checkOutput("PCD", PCD, mPcD);
      checkOutput("PCPlus4D", PCPlus4D, mPc4D);
    end
    if (reset) begin
      mPcf = RST_PC;
      mDrop = 0;
      slots.delete();
      memQ.delete();
      mValidD = 1'b0;
      mInstrD = NOP_INSTR;
      mPcD = '0;
      mPc4D = '0;
      armed = 1;
      return;
    end
    if (ImemRspValid) begin
      void'(memQ.pop_front());
      if (mDrop > 0) begin
        mDrop--;
      end else begin
        k = -1;
        foreach (slots[i])
          if (k < 0 && !slots[i].filled) k = i;
        if (k >= 0) begin
          slots[k].filled = 1;
          slots[k].instr = ImemRspData;
        end
      end
    end
    if (PCSrcE) begin
      unfilledCnt = 0;
      foreach (slots[i])
        if (!slots[i].filled) unfilledCnt++;
      mDrop += unfilledCnt;
      slots.delete();
      mPcf = PCTargetE & ~32'h3;
      mValidD = 1'b0;
      mInstrD = NOP_INSTR;
    end else begin
      if (!StallD) begin
        if (pop) begin
          mValidD = 1'b1;
          mInstrD = slots[0].instr;
          mPcD = slots[0].pc;
          mPc4D = slots[0].pc + 32'd4;
          void'(slots.pop_front());
        end else begin
          mValidD = 1'b0;
          mInstrD = NOP_INSTR;
        end
      end
      if (req && ImemReqReady) begin
        slots.push_back('{pc: mPcf, instr: 32'h0, filled: 0});
        memQ.push_back('{addr: mPcf, due: cycle + 1 + lat});
        mPcf = mPcf + 32'd4;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit rdy, input bit stl, input bit br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    cycle++;
    reset = rst;
    ImemReqReady = rdy;
    StallD = stl;
    PCSrcE = br;
    PCTargetE = tgt;
    if (!rst && memQ.size() > 0 && memQ[0].due <= cycle) begin
      ImemRspValid = 1'b1;
      ImemRspData = memWord(memQ[0].addr);
    end else begin
      ImemRspValid = 1'b0;
      ImemRspData = $urandom;
    end
    @(negedge clk);
    modelStep();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle=%0d", cycle);
    $fatal(1);
  end

  initial begin
    logic [31:0] frozen;
    logic [31:0] firstPc4;
    logic [31:0] seen[$];
    bit found;

    // Reset state, then first instruction three edges after the first accept.
    lat = 0;
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("reset ImemReqValid", {31'b0, ImemReqValid}, 32'd0);
    checkOutput("reset ValidD", {31'b0, ValidD}, 32'd0);
    checkOutput("reset InstrD", InstrD, 32'h0000_0013);
    checkOutput("reset PCD", PCD, 32'h0);
    checkOutput("reset PCPlus4D", PCPlus4D, 32'h0);
    repeat (4) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("first ValidD", {31'b0, ValidD}, 32'd1);
    checkOutput("first InstrD", InstrD, 32'h0050_0093);
    checkOutput("first PCD", PCD, 32'h0);
    checkOutput("first PCPlus4D", PCPlus4D, 32'h4);

    // Two-cycle decode stall mid-stream.
    repeat (2) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    frozen = PCD;
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("stall ImemReqValid", {31'b0, ImemReqValid}, 32'd0);
    checkOutput("stall PCD held", PCD, frozen);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("stall PCD held2", PCD, frozen);
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      if (ValidD && PCD != frozen) found = 1;
    end
    checkOutput("stall resume found", {31'b0, found}, 32'd1);
    if (found)
      checkOutput("stall resume PCD", PCD, frozen + 32'd4);

    // Memory not ready for three cycles.
    applyStimulus(1, 1, 0, 0, 0);
    repeat (3) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("notready ImemAddr", ImemAddr, 32'h0);
      checkOutput("notready ValidD", {31'b0, ValidD}, 32'd0);
    end
    seen.delete();
    repeat (8) begin
      applyStimulus(0, 1, 0, 0, 0);
      if (ValidD) seen.push_back(PCD);
    end
    checkOutput("stream count", {31'b0, seen.size() >= 3}, 32'd1);
    if (seen.size() >= 3) begin
      checkOutput("stream pc0", seen[0], 32'h0);
      checkOutput("stream pc1", seen[1], 32'h4);
      checkOutput("stream pc2", seen[2], 32'h8);
    end

    // Redirect with two requests in flight.
    applyStimulus(1, 1, 0, 0, 0);
    lat = 3;
    repeat (2) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 32'h0000_0103);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("redirect ImemReqValid", {31'b0, ImemReqValid}, 32'd1);
    checkOutput("redirect ImemAddr", ImemAddr, 32'h100);
    checkOutput("redirect ValidD", {31'b0, ValidD}, 32'd0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      if (ValidD) found = 1;
    end
    checkOutput("redirect found", {31'b0, found}, 32'd1);
    if (found)
      checkOutput("redirect first PCD", PCD, 32'h100);

    // Redirect together with stall: flush wins.
    lat = 0;
    repeat (6) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 32'h0000_0200);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("flush ValidD", {31'b0, ValidD}, 32'd0);
    checkOutput("flush ImemAddr", ImemAddr, 32'h200);

    // PC wrap, then reset mid-stream.
    applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFC);
    seen.delete();
    firstPc4 = '1;
    for (int i = 0; i < 12 && seen.size() < 2; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      if (ValidD) begin
        if (seen.size() == 0) firstPc4 = PCPlus4D;
        seen.push_back(PCD);
      end
    end
    checkOutput("wrap count", {31'b0, seen.size() >= 2}, 32'd1);
    if (seen.size() >= 2) begin
      checkOutput("wrap pc0", seen[0], 32'hFFFF_FFFC);
      checkOutput("wrap pc4", firstPc4, 32'h0);
      checkOutput("wrap pc1", seen[1], 32'h0);
    end
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("midreset ImemReqValid", {31'b0, ImemReqValid}, 32'd0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("midreset ValidD", {31'b0, ValidD}, 32'd0);
    checkOutput("midreset InstrD", InstrD, 32'h0000_0013);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("midreset ImemAddr", ImemAddr, RST_PC);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
